// File: rtl/apb_master_if.sv
// APB initiator: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns a registered response. A timeout keeps a hung slave from stalling the requester.
module apb_master_if #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic                  r_psel,        w_psel_nxt;
    logic                  r_penable,     w_penable_nxt;
    logic                  r_pwrite,      w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata,      w_pwdata_nxt;
    logic                  r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic                  r_rsp_err,     w_rsp_err_nxt;
    logic                  r_rsp_timeout, w_rsp_timeout_nxt;
    logic [CNT_W-1:0]      r_cnt,         w_cnt_nxt;

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_WIDTH{1'b0}};
            r_pwdata      <= {DATA_WIDTH{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state changes it
    always_comb begin
        w_state_nxt       = r_state;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                w_penable_nxt = 1'b0;
                if (cmd_valid) begin
                    w_pwrite_nxt = cmd_write;
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_wdata;
                    w_psel_nxt   = 1'b1;
                    w_state_nxt  = ST_SETUP;
                end else begin
                    w_psel_nxt   = 1'b0;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = {CNT_W{1'b0}};
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave takes priority over an expiring timeout
                if (pready) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_err_nxt     = pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = (!r_pwrite && !pslverr) ? prdata : {DATA_WIDTH{1'b0}};
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = {DATA_WIDTH{1'b0}};
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                end else begin
                    w_cnt_nxt         = r_cnt + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_if.sv
// Directed bench for apb_master_if: a transfer-level model predicts every
// output each cycle, and literal expectations pin the key latencies and values.
module tb_apb_master_if;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: m_age = cycles since the command was accepted (-1 = none in flight)
    int            m_age   = -1;
    bit            m_rv    = 1'b0;
    logic          m_err   = 1'b0;
    logic          m_to    = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_age <= -1; m_rv <= 1'b0; m_err <= 1'b0; m_to <= 1'b0;
            m_rdata <= '0; m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
        end else if (m_rv) begin
            if (rsp_ready) m_rv <= 1'b0;
        end else if (m_age < 0) begin
            if (cmd_valid) begin
                m_age <= 1; m_write <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
            end
        end else if (m_age >= 2 && pready) begin
            m_age <= -1; m_rv <= 1'b1; m_err <= pslverr; m_to <= 1'b0;
            m_rdata <= (!m_write && !pslverr) ? prdata : '0;
        end else if (m_age == TO + 1) begin
            m_age <= -1; m_rv <= 1'b1; m_err <= 1'b1; m_to <= 1'b1; m_rdata <= '0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_psel",      32'(psel),      32'(m_age >= 1));
            chk("m_penable",   32'(penable),   32'(m_age >= 2));
            chk("m_cmd_ready", 32'(cmd_ready), 32'(m_age < 0 && !m_rv));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("m_pwrite",    32'(pwrite),    32'(m_write));
            chk("m_paddr",     32'(paddr),     32'(m_addr));
            chk("m_pwdata",    32'(pwdata),    32'(m_wdata));
            if (m_rv) begin
                chk("m_rsp_err",     32'(rsp_err),     32'(m_err));
                chk("m_rsp_timeout", 32'(rsp_timeout), 32'(m_to));
                chk("m_rsp_rdata",   32'(rsp_rdata),   32'(m_rdata));
            end
        end
    end

    task automatic drive_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    endtask

    initial begin
        int  n_acc;
        bit  seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write
        #1 drive_cmd(1'b1, 10'h3A5, 8'hC3); pready = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("wr_setup_psel", 32'(psel), 32'd1);
        chk("wr_setup_penable", 32'(penable), 32'd0);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("wr_acc_penable", 32'(penable), 32'd1);
        chk("wr_acc_pwrite", 32'(pwrite), 32'd1);
        chk("wr_acc_paddr", 32'(paddr), 32'h3A5);
        chk("wr_acc_pwdata", 32'(pwdata), 32'hC3);
        @(negedge clk);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        chk("wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
        repeat (2) @(negedge clk);

        // Read with three wait states
        #1 drive_cmd(1'b0, 10'h010, 8'h00); pready = 1'b0;
        @(negedge clk); #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rd_wait_paddr", 32'(paddr), 32'h010);
        chk("rd_wait_penable", 32'(penable), 32'd1);
        @(negedge clk); #1 pready = 1'b1; prdata = 8'h5A;
        @(negedge clk);
        chk("rd_rsp_valid_n6", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        #1 prdata = 8'h00;
        repeat (2) @(negedge clk);

        // Slave error on a read
        #1 drive_cmd(1'b0, 10'h155, 8'h00); pslverr = 1'b1; prdata = 8'hFF;
        @(negedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("err_rsp_rdata", 32'(rsp_rdata), 32'd0);
        #1 pslverr = 1'b0; prdata = 8'h00;
        repeat (2) @(negedge clk);

        // Timeout: slave never ready
        #1 drive_cmd(1'b0, 10'h2AA, 8'h00); pready = 1'b0;
        @(negedge clk); #1 cmd_valid = 1'b0;
        n_acc = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
            if (penable) n_acc++;
        end
        chk("to_rsp_seen", 32'(seen), 32'd1);
        chk("to_access_cycles", 32'(n_acc), 32'd16);
        chk("to_psel_dropped", 32'(psel), 32'd0);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        repeat (2) @(negedge clk);

        // Backpressure with cmd_valid held, then back-to-back accept
        #1 drive_cmd(1'b1, 10'h0F0, 8'h11); pready = 1'b1; rsp_ready = 1'b0;
        @(negedge clk); #1 drive_cmd(1'b0, 10'h0F1, 8'h22);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("b2b_psel", 32'(psel), 32'd1);
        chk("b2b_paddr", 32'(paddr), 32'h0F1);
        #1 cmd_valid = 1'b0; prdata = 8'h77;
        repeat (3) @(negedge clk);
        chk("b2b_rsp_rdata", 32'(rsp_rdata), 32'h77);
        repeat (2) @(negedge clk);

        // Reset during an ACCESS wait state
        #1 drive_cmd(1'b1, 10'h3FF, 8'hEE); pready = 1'b0;
        @(negedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mr_psel", 32'(psel), 32'd0);
        chk("mr_penable", 32'(penable), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        #1 rst_n = 1'b1; pready = 1'b1;
        @(negedge clk);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);

        // Recovery transfer after reset
        #1 drive_cmd(1'b1, 10'h001, 8'h5C);
        @(negedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rec_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
